// File: rtl/tt_seq_pkg.sv
// Shared widths, FSM state encoding and golden-table lookup for the truth-table sweep sequencer.
package tt_seq_pkg;

    localparam int VEC_W = 4;
    localparam int N_VEC = 16;
    localparam int OUT_W = 3;
    localparam int ERR_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Golden {F1,F2,F3} row for one input vector.
    function automatic logic [OUT_W-1:0] exp_row(input logic [N_VEC-1:0] e1,
                                                 input logic [N_VEC-1:0] e2,
                                                 input logic [N_VEC-1:0] e3,
                                                 input logic [VEC_W-1:0] idx);
        return {e1[idx], e2[idx], e3[idx]};
    endfunction

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Bundle between the sweep sequencer and its host / function unit.
interface tt_sweep_ctrl_if;
    import tt_seq_pkg::*;

    logic             start;
    logic             abort;
    logic [OUT_W-1:0] f_in;
    logic [VEC_W-1:0] vec_out;
    logic             busy;
    logic             done;
    logic             row_valid;
    logic [VEC_W-1:0] row_idx;
    logic [OUT_W-1:0] row_f;
    logic [N_VEC-1:0] tt_f1;
    logic [N_VEC-1:0] tt_f2;
    logic [N_VEC-1:0] tt_f3;
    logic [ERR_W-1:0] err_cnt;
    logic             pass;

    modport master (
        output start, abort, f_in,
        input  vec_out, busy, done, row_valid, row_idx, row_f,
               tt_f1, tt_f2, tt_f3, err_cnt, pass
    );

    modport slave (
        input  start, abort, f_in,
        output vec_out, busy, done, row_valid, row_idx, row_f,
               tt_f1, tt_f2, tt_f3, err_cnt, pass
    );

endinterface

// File: rtl/tt_settle_timer.sv
// Loadable 4-bit down-counter; expire is high while the count sits at zero.
module tt_settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       expire
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign expire = (cnt == 4'd0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep sequencer: walks vectors 0..15, samples F1..F3, builds three tables.
// Optional golden-table compare is enabled by defining TT_SEQ_CHECK_EN.
//
//   state     | meaning
//   ST_IDLE   | waiting for start; outputs hold last sweep results
//   ST_APPLY  | vec_out driven, settle timer running
//   ST_SAMPLE | row_valid pulse, row captured into the tables
//   ST_DONE   | one-cycle done (and pass) pulse
module tt_sweep_ctrl
    import tt_seq_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [N_VEC-1:0] EXP_F1        = 16'h4A5A,
    parameter logic [N_VEC-1:0] EXP_F2        = 16'h1D15,
    parameter logic [N_VEC-1:0] EXP_F3        = 16'h2CCA
) (
    input  logic            clk,
    input  logic            rst_n,
    tt_sweep_ctrl_if.slave  bus
);

    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(N_VEC - 1);

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic             busy_r;
    logic             done_r;
    logic             row_valid_r;
    logic [VEC_W-1:0] row_idx_r;
    logic [OUT_W-1:0] row_f_r;
    logic [N_VEC-1:0] tt_f1_r;
    logic [N_VEC-1:0] tt_f2_r;
    logic [N_VEC-1:0] tt_f3_r;

    logic accept;
    logic sample_go;
    logic next_vec;
    logic sweep_end;
    logic tmr_load;
    logic tmr_expire;

    assign accept    = (state == ST_IDLE) && bus.start && !bus.abort;
    // abort in the last settle cycle wins, so that row never reaches SAMPLE
    assign sample_go = (state == ST_APPLY) && tmr_expire && !bus.abort;
    assign next_vec  = (state == ST_SAMPLE) && !bus.abort && (vec != LAST_IDX);
    assign sweep_end = (state == ST_SAMPLE) && !bus.abort && (vec == LAST_IDX);
    assign tmr_load  = accept || next_vec;

    tt_settle_timer u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (SETTLE_LOAD),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            vec         <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            row_valid_r <= 1'b0;
            row_idx_r   <= '0;
            row_f_r     <= '0;
            tt_f1_r     <= '0;
            tt_f2_r     <= '0;
            tt_f3_r     <= '0;
        end else begin
            done_r      <= 1'b0;
            row_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state   <= ST_APPLY;
                        busy_r  <= 1'b1;
                        vec     <= '0;
                        tt_f1_r <= '0;
                        tt_f2_r <= '0;
                        tt_f3_r <= '0;
                    end
                end
                ST_APPLY: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end else if (sample_go) begin
                        state        <= ST_SAMPLE;
                        row_valid_r  <= 1'b1;
                        row_idx_r    <= vec;
                        row_f_r      <= bus.f_in;
                        tt_f1_r[vec] <= bus.f_in[2];
                        tt_f2_r[vec] <= bus.f_in[1];
                        tt_f3_r[vec] <= bus.f_in[0];
                    end
                end
                ST_SAMPLE: begin
                    if (bus.abort) begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end else if (sweep_end) begin
                        state  <= ST_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        state <= ST_APPLY;
                        vec   <= vec + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef TT_SEQ_CHECK_EN
    localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(N_VEC);

    logic             row_bad;
    logic [ERR_W-1:0] err_cnt_r;
    logic             pass_r;

    assign row_bad = (bus.f_in != exp_row(EXP_F1, EXP_F2, EXP_F3, vec));

    // err_cnt is final by the time SAMPLE of vector 15 is left, so pass can use it directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r <= '0;
            pass_r    <= 1'b0;
        end else begin
            pass_r <= sweep_end && (err_cnt_r == '0);
            if (accept) begin
                err_cnt_r <= '0;
            end else if (sample_go && row_bad && (err_cnt_r != ERR_MAX)) begin
                err_cnt_r <= err_cnt_r + 5'd1;
            end
        end
    end

    assign bus.err_cnt = err_cnt_r;
    assign bus.pass    = pass_r;
`else
    logic unused_exp;
    assign unused_exp  = ^{EXP_F1, EXP_F2, EXP_F3};
    assign bus.err_cnt = '0;
    assign bus.pass    = 1'b0;
`endif

    assign bus.vec_out   = vec;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.row_valid = row_valid_r;
    assign bus.row_idx   = row_idx_r;
    assign bus.row_f     = row_f_r;
    assign bus.tt_f1     = tt_f1_r;
    assign bus.tt_f2     = tt_f2_r;
    assign bus.tt_f3     = tt_f3_r;

endmodule
